// File: rtl/sumador_pkg.sv
// Shared definitions for the sequential adder/subtractor: FSM encoding and mode constants.
package sumador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/sumador_bloque.sv
// Combinational CHUNK-bit ripple adder. The carry into the MSB is exported so the
// caller can derive two's-complement overflow on the final slice.
module sumador_bloque #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/sumador_secuencial.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// with the carry registered between slices. Subtraction is A + ~B + ~borrow_in,
// so the raw carry-out is inverted to report a borrow.
module sumador_secuencial
  import sumador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             V_o,
  output logic             Z_o
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic             mode_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic [31:0]      base;
  logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
  logic             cout_sl, cmsb_sl;
  logic             last, accept, finish;
  logic [WIDTH-1:0] res;

  assign base   = 32'(cnt_q) * 32'(CHUNK);
  assign a_sl   = a_q[base +: CHUNK];
  assign b_sl   = b_q[base +: CHUNK];
  assign last   = (cnt_q == LAST);
  assign accept = (state == IDLE) && start_i;
  assign finish = (state == RUN) && last;
  assign busy_o = (state == RUN);

  sumador_bloque #(.CHUNK(CHUNK)) u_bloque (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (cout_sl),
    .cmsb (cmsb_sl)
  );

  // Full result: accumulated lower slices with the slice being added now merged in.
  always_comb begin
    res = acc_q;
    res[base +: CHUNK] = sum_sl;
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: accept only when idle, leave RUN after the last slice.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = RUN;
      RUN:     if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture at an accepted start, then one slice per clock while running.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= A_i;
      b_q     <= (sub_i == MODE_SUB) ? ~B_i : B_i;
      acc_q   <= '0;
      mode_q  <= sub_i;
      carry_q <= (sub_i == MODE_SUB) ? ~C_i : C_i;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      acc_q[base +: CHUNK] <= sum_sl;
      carry_q              <= cout_sl;
      cnt_q                <= cnt_q + 1'b1;
    end
  end

  // Result and flag registers: updated only on the final slice, held otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_o <= 1'b0;
      S_o    <= '0;
      C_o    <= 1'b0;
      V_o    <= 1'b0;
      Z_o    <= 1'b0;
    end else begin
      done_o <= finish;
      if (finish) begin
        S_o <= res;
        C_o <= (mode_q == MODE_SUB) ? ~cout_sl : cout_sl;
        V_o <= cmsb_sl ^ cout_sl;
        Z_o <= (res == '0);
      end
    end
  end

endmodule

// File: tb/tb_sumador_secuencial.sv
// Scoreboard bench: three instances (CHUNK = 4, 16, 1) share operands; stimulus
// pushes hand-computed results plus the expected done cycle, a monitor checks them.
module tb_sumador_secuencial;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         sub;
  logic [W-1:0] a, b;
  logic         cin;

  logic         start_v [3];
  logic         busy_v  [3];
  logic         done_v  [3];
  logic [W-1:0] s_v     [3];
  logic         c_v     [3];
  logic         v_v     [3];
  logic         z_v     [3];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c, v, z;
    int           at;
  } exp_t;

  typedef struct {
    logic         sub;
    logic [W-1:0] a, b;
    logic         c;
    logic [W-1:0] s;
    logic         co, v, z;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];
  vec_t vt [10];

  sumador_secuencial #(.WIDTH(W), .CHUNK(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[0]), .sub_i(sub), .A_i(a), .B_i(b), .C_i(cin),
    .busy_o(busy_v[0]), .done_o(done_v[0]), .S_o(s_v[0]), .C_o(c_v[0]), .V_o(v_v[0]), .Z_o(z_v[0]));

  sumador_secuencial #(.WIDTH(W), .CHUNK(16)) dut16 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[1]), .sub_i(sub), .A_i(a), .B_i(b), .C_i(cin),
    .busy_o(busy_v[1]), .done_o(done_v[1]), .S_o(s_v[1]), .C_o(c_v[1]), .V_o(v_v[1]), .Z_o(z_v[1]));

  sumador_secuencial #(.WIDTH(W), .CHUNK(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_v[2]), .sub_i(sub), .A_i(a), .B_i(b), .C_i(cin),
    .busy_o(busy_v[2]), .done_o(done_v[2]), .S_o(s_v[2]), .C_o(c_v[2]), .V_o(v_v[2]), .Z_o(z_v[2]));

  function automatic int nslice(int sel);
    case (sel)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int qsize(int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic cmp(string name, int sel, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, sel, act, exp, cyc);
    end
  endtask

  task automatic check_done(int sel, exp_t e);
    cmp("S_o", sel, 32'(s_v[sel]), 32'(e.s));
    cmp("C_o", sel, 32'(c_v[sel]), 32'(e.c));
    cmp("V_o", sel, 32'(v_v[sel]), 32'(e.v));
    cmp("Z_o", sel, 32'(z_v[sel]), 32'(e.z));
    cmp("done_cycle", sel, 32'(cyc), 32'(e.at));
    cmp("busy_in_done", sel, 32'(busy_v[sel]), 32'd0);
  endtask

  task automatic unexpected(int sel);
    vectors++;
    miscompares++;
    $display("FAIL unexpected_done dut%0d: got done_o=1 expected no pending op (cycle %0d)", sel, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_v[0]) begin if (q0.size() == 0) unexpected(0); else check_done(0, q0.pop_front()); end
      if (done_v[1]) begin if (q1.size() == 0) unexpected(1); else check_done(1, q1.pop_front()); end
      if (done_v[2]) begin if (q2.size() == 0) unexpected(2); else check_done(2, q2.pop_front()); end
    end
  end

  // Drive one operation from a negedge; returns on the following negedge.
  task automatic issue(int sel, vec_t v);
    exp_t e;
    sub = v.sub; a = v.a; b = v.b; cin = v.c;
    start_v[sel] = 1'b1;
    e.s = v.s; e.c = v.co; e.v = v.v; e.z = v.z;
    e.at = cyc + 1 + nslice(sel);
    case (sel)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic wait_idle(int sel);
    for (int i = 0; i < 40; i++) begin
      if (qsize(sel) == 0) break;
      @(negedge clk);
    end
    if (qsize(sel) != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout dut%0d: got no done_o expected %0d pending", sel, qsize(sel));
      case (sel)
        0:       q0.delete();
        1:       q1.delete();
        default: q2.delete();
      endcase
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(int sel);
    cmp("rst_busy_o", sel, 32'(busy_v[sel]), 32'd0);
    cmp("rst_done_o", sel, 32'(done_v[sel]), 32'd0);
    cmp("rst_S_o",    sel, 32'(s_v[sel]),    32'd0);
    cmp("rst_C_o",    sel, 32'(c_v[sel]),    32'd0);
    cmp("rst_V_o",    sel, 32'(v_v[sel]),    32'd0);
    cmp("rst_Z_o",    sel, 32'(z_v[sel]),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    //          sub   A         B        Cin   S        C     V     Z
    vt[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vt[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vt[5] = '{1'b1, 16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
    vt[7] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vt[8] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
    vt[9] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_reset_outputs(i);
    rst = 1'b0;
    @(negedge clk);

    // Every vector on every slice width; busy width checked on the first CHUNK=4 op.
    for (int sel = 0; sel < 3; sel++) begin
      for (int i = 0; i < 10; i++) begin
        issue(sel, vt[i]);
        if (sel == 0 && i == 0) begin
          for (int k = 0; k < 4; k++) begin
            cmp("busy_run", 0, 32'(busy_v[0]), 32'd1);
            @(negedge clk);
          end
        end
        wait_idle(sel);
      end
    end

    // Restart while busy, with new operands on the pins: must be ignored.
    issue(0, vt[0]);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle(0);
    repeat (8) @(negedge clk);

    // Start in the done cycle is accepted back-to-back.
    issue(0, vt[1]);
    target = cyc + 4;
    for (int i = 0; i < 10 && cyc < target; i++) @(negedge clk);
    cmp("b2b_done_seen", 0, 32'(done_v[0]), 32'd1);
    issue(0, vt[3]);
    wait_idle(0);

    // Reset two cycles into an operation aborts it.
    sub = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sumador_secuencial.md
Name: sumador_secuencial

Overview:
- Parametrised multi-cycle adder/subtractor for WIDTH-bit operands.
- Each clock it processes one CHUNK-bit slice, LSB slice first, through a chunk ripple adder, and registers the carry between slices.
- Uses a start/busy/done handshake and reports carry/borrow, signed-overflow and zero flags.
- Serves as the arithmetic unit for datapaths that trade latency for area.

Parameters:
- WIDTH, 16, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 <= CHUNK <= WIDTH.
- NSLICE, WIDTH/CHUNK, derived number of slices (cycles per operation); not overridable.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request an operation; sampled only when idle.
- sub_i  input  1  mode: 0 = A+B+C_i, 1 = A-B-C_i (C_i acts as borrow-in).
- A_i  input  WIDTH  operand A; captured at accepted start.
- B_i  input  WIDTH  operand B; captured at accepted start.
- C_i  input  1  carry-in (add) or borrow-in (sub); captured at accepted start.
- busy_o  output  1  high while an operation is in progress.
- done_o  output  1  one-cycle pulse; results valid from this cycle.
- S_o  output  WIDTH  result; holds until the next done_o.
- C_o  output  1  carry-out (add) or borrow-out (sub).
- V_o  output  1  two's-complement overflow.
- Z_o  output  1  result equals zero.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - busy_o, done_o, S_o, C_o, V_o, Z_o all 0.
  - Internal operand, accumulator, slice counter and carry registers cleared.
- FSM states and transitions:
  - IDLE: when start_i=1, accept the operation and go to RUN.
  - RUN: go to IDLE after slice NSLICE-1 is processed.
- Capture at an accepted start:
  - A_i is latched.
  - B_i is latched as-is when sub_i=0, or bitwise inverted when sub_i=1.
  - Mode is latched.
  - Carry register is set to C_i when sub_i=0, or to ~C_i when sub_i=1.
  - Slice counter is set to 0.
- Each clock in RUN, the slice at the counter index (bits [k*CHUNK +: CHUNK]) is added with the carry register:
  - The sum slice is written into the accumulator.
  - The carry register takes the slice carry-out.
  - The counter increments.
- On the final slice:
  - Raw carry-in to the MSB and raw carry-out of the MSB are taken from the chunk adder.
  - S_o is loaded from the accumulator with the final slice merged in.
  - C_o = raw carry-out (add) or its inverse (sub).
  - V_o = carry-into-MSB XOR carry-out-of-MSB.
  - Z_o = (result == 0).
  - done_o = 1 for exactly one cycle; state returns to IDLE.
- Latency: if start_i is sampled at edge t, done_o is high and results are valid in the cycle after edge t+NSLICE. With CHUNK=WIDTH this is 1 cycle.
- busy_o = 1 exactly while in RUN, i.e. from the cycle after the accepted start until the cycle done_o is high. busy_o is 0 in the done cycle.
- Boundary conditions:
  - start_i while busy is ignored; captured operands are unaffected.
  - start_i in the done_o cycle is accepted: back-to-back operation with no gap cycle.
  - Changes to A_i, B_i, sub_i or C_i after capture have no effect on the operation in flight.
  - rst_i mid-operation aborts it: no done_o, and outputs return to their reset values on that edge.
  - Result outputs change only on a done_o edge or on reset.

Decomposition:
- Shared package sumador_pkg holds:
  - FSM state encoding (IDLE, RUN).
  - Constants for mode encoding (MODE_ADD=0, MODE_SUB=1).
- One sub-module, sumador_bloque: combinational CHUNK-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, plus carry into its MSB for overflow detection.
  - Instantiated once and reused each cycle.

Test Plan:
- Plain add (WIDTH=16, CHUNK=4): add 0x1234+0x4321, C_i=0 -> S_o=0x5555, C_o=0, V_o=0, Z_o=0; busy_o high 4 cycles; done_o exactly 4 edges after start.
- Carry and zero: add 0xFFFF+0x0001, C_i=0 -> S_o=0x0000, C_o=1, Z_o=1, V_o=0. Then add 0x7FFF+0x0001 -> S_o=0x8000, V_o=1, C_o=0.
- Subtract, overflow: sub 0x8000-0x0001, C_i=0 -> S_o=0x7FFF, V_o=1, C_o(borrow)=0.
- Subtract, borrow: sub 0x0000-0x0001, C_i=0 -> S_o=0xFFFF, C_o=1, V_o=0. Then sub 0x0005-0x0002, C_i=1 -> S_o=0x0002, C_o=0.
- Handshake: start_i pulsed again 2 cycles into an operation with different operands -> ignored, first result unchanged. start_i in the done cycle -> second operation accepted, its done_o 4 cycles later.
- Reset and configurations: rst_i asserted 2 cycles into an operation -> next cycle busy_o=0, all outputs 0, no done_o. Repeat the first scenario with CHUNK=16 (done after 1 cycle) and CHUNK=1 (done after 16 cycles) -> identical result.
